clint_timer: RTL and testbench



---
 rtl/clint_timer.sv | 140 ++++++++++++++
 tb/tb_clint_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// clint_timer: machine timer (mtime/mtimecmp) and software interrupt (msip)
// register block. It is a slave on the data-memory bus and allows one
// outstanding request at a time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid_i/ready_o request handshake; ready only while idle
//   req_we_i            1 = write, 0 = read
//   req_addr_i          byte address (64-bit)
//   req_wdata_i/wstrb_i write data and byte enables
//   resp_valid_o/ready_i response handshake; response held until taken
//   resp_rdata_o        read data (0 for writes and errors)
//   resp_err_o          unmapped or misaligned access
//   tmr_irq_o           registered level of (mtime >= mtimecmp)
//   sft_irq_o           msip bit 0
module clint_timer #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   input  logic [7:0]  req_wstrb_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        tmr_irq_o,
   output logic        sft_irq_o
);
   localparam logic [15:0] OFF_MSIP = 16'h0000;
   localparam logic [15:0] OFF_CMP  = 16'h4000;
   localparam logic [15:0] OFF_TIME = 16'hBFF8;
   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

   typedef enum logic {S_IDLE, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [63:0] mtime_q, mtimecmp_q;
   logic        msip_q;
   logic [15:0] presc_q;
   logic [63:0] rdata_q;
   logic        err_q;
   logic        tmr_irq_q;

   logic [63:0] rel_addr;
   logic        addr_ok, hit_msip, hit_cmp, hit_time, hit_any;
   logic        accept, wr, time_wr;
   logic [63:0] bmask, rd_val, mtime_inc;
   logic        tick;

   // Offset within the window; anything outside the window or misaligned
   // is treated as an error rather than aliased.
   assign rel_addr = req_addr_i - BASE_ADDR;
   assign addr_ok  = (rel_addr[63:16] == 48'd0) && (rel_addr[2:0] == 3'd0);
   assign hit_msip = addr_ok && (rel_addr[15:0] == OFF_MSIP);
   assign hit_cmp  = addr_ok && (rel_addr[15:0] == OFF_CMP);
   assign hit_time = addr_ok && (rel_addr[15:0] == OFF_TIME);
   assign hit_any  = hit_msip || hit_cmp || hit_time;

   assign accept  = (state_q == S_IDLE) && req_valid_i;
   assign wr      = accept && req_we_i;
   // An all-zero strobe is a pure no-op, so it must not disturb the prescaler.
   assign time_wr = wr && hit_time && (req_wstrb_i != 8'h00);

   assign tick      = (presc_q == DIV_LAST);
   assign mtime_inc = mtime_q + {63'd0, tick};

   always_comb begin
      bmask = '0;
      for (int b = 0; b < 8; b++) bmask[b*8 +: 8] = {8{req_wstrb_i[b]}};
   end

   // Read mux sees pre-update register values.
   always_comb begin
      rd_val = '0;
      if (hit_msip) rd_val = {63'd0, msip_q};
      if (hit_cmp)  rd_val = mtimecmp_q;
      if (hit_time) rd_val = mtime_q;
   end

   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         presc_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         tmr_irq_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_irq_q <= (mtime_q >= mtimecmp_q);

         // Written bytes win; unwritten bytes still see this cycle's tick.
         if (time_wr) mtime_q <= (req_wdata_i & bmask) | (mtime_inc & ~bmask);
         else         mtime_q <= mtime_inc;

         if (time_wr || tick) presc_q <= '0;
         else                 presc_q <= presc_q + 16'd1;

         if (wr && hit_cmp)
            mtimecmp_q <= (req_wdata_i & bmask) | (mtimecmp_q & ~bmask);
         if (wr && hit_msip && req_wstrb_i[0])
            msip_q <= req_wdata_i[0];

         if (accept) begin
            err_q   <= !hit_any;
            rdata_q <= (req_we_i || !hit_any) ? 64'd0 : rd_val;
         end
      end
   end

   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;
   assign tmr_irq_o    = tmr_irq_q;
   assign sft_irq_o    = msip_q;
endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: reference model of the register block (mtime kept
// as "value at last write + elapsed cycles / TICK_DIV"), per-cycle output
// compare, directed cases with literal expectations, then random traffic.
module tb_clint_timer;
   localparam int unsigned DIV  = 4;
   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, resp_ready_i = 1'b0;
   logic [63:0] req_addr_i = '0, req_wdata_i = '0;
   logic [7:0]  req_wstrb_i = '0;
   logic        req_ready_o, resp_valid_o, resp_err_o, tmr_irq_o, sft_irq_o;
   logic [63:0] resp_rdata_o;

   clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .tmr_irq_o(tmr_irq_o), .sft_irq_o(sft_irq_o)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0]     m_base, m_cmp, m_rdata;
   longint unsigned m_age;
   logic            m_msip, m_busy, m_err, m_irq;

   function automatic logic [63:0] m_now();
      return m_base + 64'(m_age / DIV);
   endfunction

   always @(posedge clk or negedge rst_n) begin : mdl
      logic [63:0] cur, inc, mask, off;
      logic        tick, nirq, hm, hc, ht;
      if (!rst_n) begin
         m_base = '0; m_age = 0; m_cmp = '1; m_msip = 0;
         m_busy = 0; m_rdata = '0; m_err = 0; m_irq = 0;
      end else begin
         cur  = m_now();
         tick = (m_age % DIV) == DIV - 1;
         inc  = cur + (tick ? 64'd1 : 64'd0);
         nirq = cur >= m_cmp;
         m_age = m_age + 1;
         if (m_busy) begin
            if (resp_ready_i) m_busy = 0;
         end else if (req_valid_i) begin
            off = req_addr_i - BASE;
            hm = off == 64'h0; hc = off == 64'h4000; ht = off == 64'hBFF8;
            m_busy  = 1;
            m_err   = !(hm || hc || ht);
            m_rdata = '0;
            for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{req_wstrb_i[b]}};
            if (!req_we_i) begin
               if (hm) m_rdata = {63'd0, m_msip};
               if (hc) m_rdata = m_cmp;
               if (ht) m_rdata = cur;
            end else begin
               if (hm && req_wstrb_i[0]) m_msip = req_wdata_i[0];
               if (hc) m_cmp = (req_wdata_i & mask) | (m_cmp & ~mask);
               if (ht && req_wstrb_i != 8'h00) begin
                  m_base = (req_wdata_i & mask) | (inc & ~mask);
                  m_age  = 0;
               end
            end
         end
         m_irq = nirq;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("req_ready", {63'd0, req_ready_o}, {63'd0, !m_busy});
         chk("resp_valid", {63'd0, resp_valid_o}, {63'd0, m_busy});
         chk("resp_rdata", resp_rdata_o, m_rdata);
         chk("resp_err", {63'd0, resp_err_o}, {63'd0, m_err});
         chk("tmr_irq", {63'd0, tmr_irq_o}, {63'd0, m_irq});
         chk("sft_irq", {63'd0, sft_irq_o}, {63'd0, m_msip});
      end
   end

   // One bus transaction; acc = cycle count of the accepting edge.
   task automatic bus(input logic we, input logic [63:0] off, input logic [63:0] wd,
                      input logic [7:0] st, input int hold,
                      output logic [63:0] rd, output logic er, output int acc);
      int n;
      @(negedge clk);
      req_valid_i = 1; req_we_i = we; req_addr_i = BASE + off;
      req_wdata_i = wd; req_wstrb_i = st;
      n = 0;
      while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
      if (!req_ready_o) chk("accept_timeout", {63'd0, req_ready_o}, 64'd1);
      @(posedge clk); #1;
      acc = cyc; req_valid_i = 0;
      @(negedge clk);
      rd = resp_rdata_o; er = resp_err_o;
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         chk("hold_valid", {63'd0, resp_valid_o}, 64'd1);
         chk("hold_ready", {63'd0, req_ready_o}, 64'd0);
         chk("hold_rdata", resp_rdata_o, rd);
      end
      resp_ready_i = 1;
      @(negedge clk);
      resp_ready_i = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd, wd, off;
      logic        er, we;
      logic [7:0]  st;
      int          a, w, r0, n;

      repeat (3) @(negedge clk);
      rst_n = 1; r0 = cyc;
      @(negedge clk);
      chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
      chk("rst_valid", {63'd0, resp_valid_o}, 64'd0);
      chk("rst_irq", {63'd0, tmr_irq_o}, 64'd0);
      chk("rst_rdata", resp_rdata_o, 64'd0);

      bus(0, 64'h4000, 0, 8'h00, 0, rd, er, a);
      chk("cmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("cmp_reset_err", {63'd0, er}, 64'd0);
      bus(0, 64'hBFF8, 0, 8'h00, 0, rd, er, a);
      chk("mtime_early", rd, 64'((a - 1 - r0) / int'(DIV)));

      // irq rises one cycle after mtime reaches mtimecmp
      bus(1, 64'hBFF8, 64'd0, 8'hFF, 0, rd, er, w);
      bus(1, 64'h4000, 64'd10, 8'hFF, 0, rd, er, a);
      n = 0;
      while (!tmr_irq_o && n < 200) begin @(negedge clk); n++; end
      chk("irq_rise_cycle", 64'(cyc - w), 64'd41);
      bus(1, 64'h4000, 64'd100, 8'hFF, 0, rd, er, a);
      chk("irq_fall", {63'd0, tmr_irq_o}, 64'd0);

      // msip
      bus(1, 64'h0, '1, 8'hFF, 0, rd, er, a);
      bus(0, 64'h0, 0, 8'h00, 0, rd, er, a);
      chk("msip_read", rd, 64'd1);
      chk("sft_high", {63'd0, sft_irq_o}, 64'd1);
      bus(1, 64'h0, 64'd0, 8'hFF, 0, rd, er, a);
      chk("sft_low", {63'd0, sft_irq_o}, 64'd0);

      // wrap
      bus(1, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, er, w);
      repeat (8) @(negedge clk);
      bus(0, 64'hBFF8, 0, 8'h00, 0, rd, er, a);
      chk("mtime_wrap", rd, 64'd0);

      // byte write coinciding with a tick
      bus(1, 64'hBFF8, 64'hFE, 8'hFF, 0, rd, er, w);
      while (cyc != w + 6) @(negedge clk);
      bus(1, 64'hBFF8, 64'hAA, 8'h01, 0, rd, er, a);
      chk("tick_write_edge", 64'(a - w), 64'd8);
      bus(0, 64'hBFF8, 0, 8'h00, 0, rd, er, a);
      chk("byte_tick_merge", rd, 64'h1AA);

      // errors, held response, no-op strobe
      bus(0, 64'h0008, 0, 8'h00, 3, rd, er, a);
      chk("err8_flag", {63'd0, er}, 64'd1);
      chk("err8_rdata", rd, 64'd0);
      bus(0, 64'h4004, 0, 8'h00, 3, rd, er, a);
      chk("err4004_flag", {63'd0, er}, 64'd1);
      chk("err4004_rdata", rd, 64'd0);
      bus(1, 64'h0008, '1, 8'hFF, 0, rd, er, a);
      bus(1, 64'h4000, 64'd5, 8'h00, 0, rd, er, a);
      chk("nostrb_err", {63'd0, er}, 64'd0);
      bus(0, 64'h4000, 0, 8'h00, 0, rd, er, a);
      chk("cmp_unchanged", rd, 64'd100);
      bus(0, 64'h0, 0, 8'h00, 0, rd, er, a);
      chk("msip_unchanged", rd, 64'd0);

      // async reset during a pending response with both irqs high
      bus(1, 64'h0, 64'd1, 8'h01, 0, rd, er, a);
      bus(1, 64'h4000, 64'd0, 8'hFF, 0, rd, er, a);
      @(negedge clk);
      chk("pre_rst_irq", {63'd0, tmr_irq_o}, 64'd1);
      req_valid_i = 1; req_we_i = 0; req_addr_i = BASE + 64'h4000;
      @(posedge clk); #1; req_valid_i = 0;
      @(negedge clk);
      chk("pre_rst_valid", {63'd0, resp_valid_o}, 64'd1);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", {63'd0, resp_valid_o}, 64'd0);
      chk("arst_irq", {63'd0, tmr_irq_o}, 64'd0);
      chk("arst_sft", {63'd0, sft_irq_o}, 64'd0);
      chk("arst_ready", {63'd0, req_ready_o}, 64'd1);
      @(negedge clk); rst_n = 1;

      // random traffic
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            0:       off = 64'h0;
            1, 2:    off = 64'h4000;
            3, 4:    off = 64'hBFF8;
            5:       off = 64'h0008;
            6:       off = 64'hBFFC;
            default: off = 64'($urandom_range(0, 16'hFFFF));
         endcase
         we = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         wd = {$urandom, $urandom};
         if (off == 64'h4000 && $urandom_range(0, 1) == 1)
            wd = m_now() + 64'($urandom_range(0, 20)) - 64'd10;
         if (off == 64'hBFF8 && $urandom_range(0, 1) == 1)
            wd = m_cmp - 64'($urandom_range(0, 12));
         bus(we, off, wd, st, $urandom_range(0, 3), rd, er, a);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
